// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - unsigned 8x8 shift-and-add multiply sequencer driving the shared 8-bit ALU
module alu_mul_seq #(
  parameter logic [7:0] ADD_CINS = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_cins,
  output logic        alu_oe,
  output logic        alu_carryin,
  input  logic [7:0]  alu_out,
  input  logic        alu_carryout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  mcand_r;
  logic [7:0]  acc_hi;
  logic [7:0]  acc_lo;
  logic [2:0]  cnt;
  logic [8:0]  step_sum;
  logic        in_run;

  assign in_run = (state == S_RUN);

  // Partial-product add comes from the ALU only when the current multiplier bit is set.
  always_comb begin
    step_sum = {1'b0, acc_hi};
    if (acc_lo[0]) begin
      step_sum = {alu_carryout, alu_out};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand_r <= 8'h00;
      acc_hi  <= 8'h00;
      acc_lo  <= 8'h00;
      cnt     <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_r <= mcand;
            acc_hi  <= 8'h00;
            acc_lo  <= mplier;
            cnt     <= 3'd0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          // 17-bit right shift of {carry, sum, multiplier remainder}.
          {acc_hi, acc_lo} <= {step_sum, acc_lo[7:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign product     = {acc_hi, acc_lo};
  assign alu_oe      = in_run & acc_lo[0];
  assign alu_a       = in_run ? acc_hi : 8'h00;
  assign alu_b       = in_run ? mcand_r : 8'h00;
  assign alu_cins    = ADD_CINS;
  assign alu_carryin = 1'b0;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned 8x8 multiply sequencer that drives the shared 8-bit ALU. It implements shift-and-add over 8 iterations and uses the ALU's adder and carry-out for each partial-product add. The shift and accumulation are done internally. It sits beside the ALU in the datapath and owns the ALU operand, control and enable lines while busy. It returns a 16-bit product with a one-cycle done pulse.

## Interface

Parameters:
- ADD_CINS, 8'h00, ALU control-ROM index selecting plain A+B with incoming carry ignored and output not inverted.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request multiply; sampled only in IDLE
- mcand  in  8  multiplicand; captured on accepted start
- mplier  in  8  multiplier; captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse when product is valid
- product  out  16  result; holds until the next accepted start
- alu_a  out  8  ALU operand A (accumulator high byte)
- alu_b  out  8  ALU operand B (latched multiplicand)
- alu_cins  out  8  ALU control index; constant ADD_CINS
- alu_oe  out  1  ALU output enable
- alu_carryin  out  1  ALU carry in; tied 0
- alu_out  in  8  ALU result
- alu_carryout  in  1  ALU carry out (bit 8 of sum)

## Operation

- Registers:
  - state (IDLE/RUN/DONE)
  - mcand_r[7:0]
  - acc_hi[7:0]
  - acc_lo[7:0]
  - cnt[2:0]
- IDLE, start=1:
  - mcand_r<=mcand
  - acc_hi<=0
  - acc_lo<=mplier
  - cnt<=0
  - go to RUN
- IDLE, start=0: hold all registers.
- RUN, one iteration per cycle:
  - If acc_lo[0]=1: {c,s} = {alu_carryout, alu_out}.
  - Else: {c,s} = {0, acc_hi}. The ALU result is ignored.
  - Update {acc_hi, acc_lo} <= {c, s, acc_lo[7:1]}, a 17-bit right shift.
  - cnt<=cnt+1.
  - When cnt==7 at the edge, go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Go to IDLE unconditionally.
  - start in DONE is ignored.
- product = {acc_hi, acc_lo}, continuously.
  - Valid from the DONE cycle.
  - Stable in IDLE until the next accepted start clears acc_hi.
- ALU drive:
  - alu_oe = (state==RUN) & acc_lo[0].
  - In RUN: alu_a=acc_hi, alu_b=mcand_r.
  - Otherwise alu_a=alu_b=0.
  - alu_cins=ADD_CINS and alu_carryin=0 at all times.
- Arithmetic:
  - Unsigned only.
  - Sum width is 9 bits. The carry is shifted into acc_hi[7], so no bit is lost.
  - The final value is exactly mcand*mplier mod 2^16, with no overflow possible.
- start while busy (RUN or DONE): ignored. There is no queueing and latched operands are unchanged.
- ALU overout/cmpo are not used.

## Timing

- Reset (rst_n=0 at a clock edge):
  - state=IDLE; mcand_r, acc_hi, acc_lo and cnt = 0.
  - busy=0, done=0, product=0, alu_oe=0, alu_a=alu_b=0.
- Reset mid-RUN or in DONE aborts the operation: no done pulse, product reads 0 from the next cycle.
- Latency, with start accepted at edge 0:
  - RUN occupies cycles 1-8.
  - DONE and done=1 in cycle 9.
  - IDLE in cycle 10.
  - Earliest next accepted start is sampled at edge 10.
- busy rises the cycle after the accepted start and falls entering IDLE.
- ALU path is combinational (alu_a/alu_b -> alu_out -> acc). The acc update uses the ALU result from the same cycle.

## Test plan

- Small product: mcand=0x0F, mplier=0x11, start one cycle -> busy for 9 cycles, done in cycle 9, product=0x00FF; alu_oe high only in RUN cycles 1 and 5.
- Carry path: 0xFF x 0xFF -> product=0xFE01; alu_carryout=1 is observed feeding acc_hi[7].
- Zero multiplier: 0xAB x 0x00 -> alu_oe never asserted; product=0x0000 with done in cycle 9.
- start while busy: start 0x02x0x03, then re-assert start with 0x10x0x10 in cycles 3 and 9 -> product=0x0006, exactly one done; next start in IDLE gives 0x0100.
- Reset mid-op: start 0x80x0x80, drop rst_n in cycle 5 -> state IDLE, product=0, no done, busy=0; a fresh 0x80x0x80 yields 0x4000.
- Hold: after 0x12x0x34=0x03A8, idle 20 cycles -> product stays 0x03A8 and done stays 0.
